fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- PC generator and instruction fetch front end of the 3-stage core; sits directly upstream of decode and the branch-resolution logic.
- Consumes the taken-branch select and branch target produced in decode (plus jump redirects), drives the instruction-memory request/response handshake, and buffers fetched words in a 2-entry queue.
- Presents instD/pcD/pc_plus4D to decode, and discards stale in-flight responses after any redirect.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h4000_0000, first fetch address after reset.
- NOP_INSN, 32'h0000_0013, value held on instD when validD=0.

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- PCSel_bit1  input  1  conditional branch taken (from decode).
- BTarg  input  XLEN  branch target.
- jump_valid  input  1  JAL/JALR redirect request.
- jump_targ  input  XLEN  jump target.
- stallD  input  1  decode cannot accept an instruction this cycle.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  XLEN  fetch address, bits[1:0] always 0.
- imem_rsp_valid  input  1  response data valid, one cycle pulse per accepted request.
- imem_rsp_data  input  32  fetched instruction word.
- validD  output  1  instD/pcD hold a live instruction.
- instD  output  32  instruction to decode.
- pcD  output  XLEN  PC of instD.
- pc_plus4D  output  XLEN  pcD+4 (wraps mod 2^XLEN).

Behaviour:
- Reset (async assert, any state): FSM=S_BOOT, fetch_pc=RESET_PC, queue empty, outstanding=0, kill=0. Outputs: imem_req_valid=0, imem_addr=RESET_PC, validD=0, instD=NOP_INSN, pcD=0, pc_plus4D=4.
- FSM states:
  - S_BOOT: one cycle after reset release, then S_FETCH.
  - S_FETCH: normal issue.
  - S_DRAIN: redirect taken while a request is outstanding; waits for the stale response.
- Issue rule in S_FETCH: imem_req_valid=1 when outstanding=0 and (queue occupancy + outstanding) < 2. imem_addr=fetch_pc.
  - Handshake fires on valid&&ready: outstanding<=1 and fetch_pc<=fetch_pc+4 (wraps).
  - At most one request is outstanding.
  - imem_req_valid may drop without ready only on a redirect; the address is then replaced.
- Response: imem_rsp_valid with outstanding=1 and kill=0 pushes {data, pc}; outstanding<=0.
  - Data must not arrive in the same cycle as the request is accepted (latency >= 1).
  - A response while outstanding=0 is a protocol error and is ignored.
  - A request may be issued in the same cycle a response retires (outstanding treated as 0 for issue if rsp_valid).
- Decode side: validD = queue non-empty; head presented combinationally. Pop on validD && !stallD.
  - Push and pop in the same cycle are allowed at occupancy 1 or 2.
  - Push to a full queue cannot occur by construction; a bench assertion checks this.
- Redirect: redirect = PCSel_bit1 || jump_valid. Priority: PCSel_bit1 (BTarg) over jump_valid (jump_targ). Target bits[1:0] forced to 0.
  - In the redirect cycle, the current head pop still counts (the branch itself is consumed).
  - At the clock edge: queue flushed, fetch_pc<=target.
  - If a request is outstanding (or accepted this same cycle): kill<=1, state<=S_DRAIN. Otherwise stay in S_FETCH.
  - Target request is issued in cycle N+1 when there is no in-flight request. validD=0 in cycle N+1.
- S_DRAIN: imem_req_valid=0.
  - On imem_rsp_valid: data dropped, kill<=0, outstanding<=0, state<=S_FETCH.
  - The target request is issued on the next cycle.
  - A further redirect in S_DRAIN only updates fetch_pc (newest wins).
- Redirect while stallD=1 is still honoured (flush overrides stall).
- pc_plus4D = pcD+4 from the stored PC, not recomputed from fetch_pc.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response latency -> first imem_addr=0x4000_0000 one cycle after S_BOOT; validD sequence with pcD 0x4000_0000, 0x4000_0004, 0x4000_0008; pc_plus4D = pcD+4.
- stallD held high 6 cycles -> queue fills to 2, imem_req_valid drops; no loss or duplication; on release, pcD resumes in order.
- PCSel_bit1=1, BTarg=0x4000_0100, with one request outstanding (latency 3) -> stale word dropped, validD=0 until word for 0x4000_0100 arrives; no pcD=old+4 ever appears.
- PCSel_bit1=1 and jump_valid=1 in the same cycle (BTarg=0x200, jump_targ=0x300) -> next fetch address is 0x200; jump_targ=0x303 alone -> address 0x300.
- imem_req_ready=0 for 4 cycles, then a redirect to 0x80 -> imem_addr changes to 0x80 with no request accepted for the old address; accepted once ready=1.
- rst_n pulsed low mid-stream with a response outstanding -> outputs immediately at reset values; the late rsp_valid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC sequencing, single-outstanding instruction-memory handshake,
// 2-entry fetch queue toward decode, and redirect/kill handling for stale responses.
module fetch_pc_unit #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h4000_0000,
    parameter logic [31:0]       NOP_INSN = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCSel_bit1,
    input  logic [XLEN-1:0] BTarg,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_targ,
    input  logic            stallD,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            validD,
    output logic [31:0]     instD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pc_plus4D
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            outstanding;
    logic            kill;

    logic [31:0]     q_data [2];
    logic [XLEN-1:0] q_pc   [2];
    logic            q_head;
    logic [1:0]      q_count;
    logic            wr_idx;

    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            rsp_retire;
    logic            rsp_ok;
    logic            push_en;
    logic            pop_en;
    logic            req_fire;
    logic [2:0]      occupancy;

    always_comb begin
        redirect        = PCSel_bit1 || jump_valid;
        redirect_target = (PCSel_bit1 ? BTarg : jump_targ) & ~XLEN'(3);
    end

    // A response only counts while a request is outstanding; under kill it is discarded.
    always_comb begin
        rsp_retire = imem_rsp_valid && outstanding;
        rsp_ok     = rsp_retire && !kill;
        push_en    = rsp_ok && !redirect;
        pop_en     = validD && !stallD;
        wr_idx     = q_head ^ q_count[0];
    end

    // The in-flight response already owns a queue slot, so it stays in the occupancy sum
    // even while it retires; a pop this cycle frees one.
    always_comb begin
        occupancy      = {1'b0, q_count} + {2'b00, outstanding} - {2'b00, pop_en};
        imem_req_valid = (state == S_FETCH) && (!outstanding || imem_rsp_valid)
                         && (occupancy < 3'd2);
        req_fire       = imem_req_valid && imem_req_ready;
        imem_addr      = fetch_pc;
    end

    always_comb begin
        validD    = (q_count != 2'd0);
        instD     = validD ? q_data[q_head] : NOP_INSN;
        pcD       = validD ? q_pc[q_head]   : '0;
        pc_plus4D = pcD + XLEN'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            kill        <= 1'b0;
            q_head      <= 1'b0;
            q_count     <= 2'd0;
        end else begin
            if (req_fire) begin
                outstanding <= 1'b1;
                req_pc      <= fetch_pc;
            end else if (rsp_retire) begin
                outstanding <= 1'b0;
            end

            case (state)
                S_BOOT: begin
                    state <= S_FETCH;
                    if (redirect) fetch_pc <= redirect_target;
                end
                S_FETCH: begin
                    if (redirect) begin
                        fetch_pc <= redirect_target;
                        if (req_fire || (outstanding && !imem_rsp_valid)) begin
                            kill  <= 1'b1;
                            state <= S_DRAIN;
                        end
                    end else if (req_fire) begin
                        fetch_pc <= fetch_pc + XLEN'(4);
                    end
                end
                S_DRAIN: begin
                    if (redirect) fetch_pc <= redirect_target;
                    if (!outstanding || imem_rsp_valid) begin
                        kill  <= 1'b0;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_BOOT;
            endcase

            // Flush beats both push and stall: the branch in the head is consumed either way.
            if (redirect) begin
                q_head  <= 1'b0;
                q_count <= 2'd0;
            end else begin
                if (pop_en) q_head <= ~q_head;
                q_count <= q_count + {1'b0, push_en} - {1'b0, pop_en};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            q_data[wr_idx] <= imem_rsp_data;
            q_pc[wr_idx]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a memory model answers fetches with addr^KEY and a
// monitor matches every retired instruction against hand-listed expected PCs.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] DATA_KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSel_bit1;
    logic [31:0] BTarg;
    logic        jump_valid;
    logic [31:0] jump_targ;
    logic        stallD;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        validD;
    logic [31:0] instD;
    logic [31:0] pcD;
    logic [31:0] pc_plus4D;

    int          pass_count  = 0;
    int          total_count = 0;
    logic [31:0] exp_q[$];

    int          cycle_no = 0;
    int          mem_lat = 1;
    logic        mem_accept_now = 1'b0;
    int          accept_count = 0;
    logic [31:0] acc_log[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    fetch_pc_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PCSel_bit1     (PCSel_bit1),
        .BTarg          (BTarg),
        .jump_valid     (jump_valid),
        .jump_targ      (jump_targ),
        .stallD         (stallD),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .validD         (validD),
        .instD          (instD),
        .pcD            (pcD),
        .pc_plus4D      (pc_plus4D)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic reportFail(input string name, input int actual, input int expected);
        total_count++;
        $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Drives one cycle of inputs at the falling edge; returns after the monitor has sampled.
    task automatic applyStimulus(input logic stall, input logic pcsel, input logic [31:0] btarg,
                                 input logic jv, input logic [31:0] jtarg, input logic ready);
        @(negedge clk);
        stallD         = stall;
        PCSel_bit1     = pcsel;
        BTarg          = btarg;
        jump_valid     = jv;
        jump_targ      = jtarg;
        imem_req_ready = ready;
        #3;
    endtask

    task automatic waitRetireAll(input int max_cycles, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
            n++;
        end
        if (exp_q.size() != 0) reportFail(name, exp_q.size(), 0);
    endtask

    task automatic waitAccept(input int max_cycles, input string name);
        int n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
            n++;
        end while (!mem_accept_now && n < max_cycles);
        if (!mem_accept_now) reportFail(name, 0, 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        checkOutput({tag, "_imem_addr"}, imem_addr, RESET_PC);
        checkOutput({tag, "_validD"}, {31'b0, validD}, 32'd0);
        checkOutput({tag, "_instD"}, instD, NOP_INSN);
        checkOutput({tag, "_pcD"}, pcD, 32'd0);
        checkOutput({tag, "_pc_plus4D"}, pc_plus4D, 32'd4);
    endtask

    initial begin : memory_model
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            cycle_no++;
            mem_accept_now = 1'b0;
            if (mem_due_q.size() != 0 && mem_due_q[0] == cycle_no) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_addr_q[0] ^ DATA_KEY;
                mem_due_q.delete(0);
                mem_addr_q.delete(0);
            end else begin
                imem_rsp_valid = 1'b0;
            end
            #1;
            if (rst_n && imem_req_valid && imem_req_ready) begin
                if (mem_due_q.size() != 0) reportFail("multi_outstanding", mem_due_q.size() + 1, 1);
                if (imem_addr[1:0] != 2'b00) reportFail("addr_align", int'(imem_addr[1:0]), 0);
                mem_addr_q.push_back(imem_addr);
                mem_due_q.push_back(cycle_no + mem_lat);
                acc_log.push_back(imem_addr);
                mem_accept_now = 1'b1;
                accept_count++;
            end
        end
    end

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (validD && !stallD) begin
                    if (exp_q.size() == 0) begin
                        $display("[TB] FAIL unexpected_retire: got pcD 0x%08h, expected none", pcD);
                        total_count++;
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("retire_pcD", pcD, e);
                        checkOutput("retire_instD", instD, e ^ DATA_KEY);
                        checkOutput("retire_pc_plus4D", pc_plus4D, e + 32'd4);
                    end
                end
                if (PCSel_bit1 || jump_valid) exp_q.delete();
                if (dut.q_count == 2'd2 && dut.push_en && !dut.pop_en)
                    reportFail("push_to_full_queue", 1, 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int acc_before;
        int n;
        rst_n          = 1'b0;
        stallD         = 1'b0;
        PCSel_bit1     = 1'b0;
        BTarg          = '0;
        jump_valid     = 1'b0;
        jump_targ      = '0;
        imem_req_ready = 1'b1;

        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        checkOutput("boot_req_valid", {31'b0, imem_req_valid}, 32'd0);
        exp_q.push_back(32'h4000_0000);
        exp_q.push_back(32'h4000_0004);
        exp_q.push_back(32'h4000_0008);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("first_imem_addr", imem_addr, 32'h4000_0000);
        waitRetireAll(20, "stream_timeout");

        $display("[TB] stall for 6 cycles");
        repeat (6) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("stall_validD", {31'b0, validD}, 32'd1);
        checkOutput("stall_head_pcD", pcD, 32'h4000_000C);
        exp_q.push_back(32'h4000_000C);
        exp_q.push_back(32'h4000_0010);
        exp_q.push_back(32'h4000_0014);
        exp_q.push_back(32'h4000_0018);
        waitRetireAll(20, "stall_release_timeout");

        $display("[TB] branch with a request outstanding");
        mem_lat = 3;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h4000_001C + 32'(4 * i));
        waitAccept(20, "accept_timeout");
        applyStimulus(1'b0, 1'b1, 32'h4000_0100, 1'b0, '0, 1'b1);
        exp_q.push_back(32'h4000_0100);
        exp_q.push_back(32'h4000_0104);
        exp_q.push_back(32'h4000_0108);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("post_branch_validD", {31'b0, validD}, 32'd0);
        waitRetireAll(40, "branch_target_timeout");

        $display("[TB] redirect priority");
        mem_lat = 1;
        applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 1'b1);
        exp_q.push_back(32'h0000_0200);
        exp_q.push_back(32'h0000_0204);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("priority_imem_addr", imem_addr, 32'h0000_0200);
        waitRetireAll(30, "priority_timeout");
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 32'h0000_0303, 1'b1);
        exp_q.push_back(32'h0000_0300);
        exp_q.push_back(32'h0000_0304);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("jump_imem_addr", imem_addr, 32'h0000_0300);
        waitRetireAll(30, "jump_timeout");

        $display("[TB] redirect while memory not ready");
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 32'h4000_1000, 1'b0);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
            n++;
        end while (!imem_req_valid && n < 10);
        if (!imem_req_valid) reportFail("ready_low_issue_timeout", 0, 1);
        acc_before = accept_count;
        repeat (4) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("held_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("held_imem_addr", imem_addr, 32'h4000_1000);
        applyStimulus(1'b1, 1'b1, 32'h0000_0080, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("redirected_imem_addr", imem_addr, 32'h0000_0080);
        checkOutput("redirected_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("no_accept_while_not_ready", 32'(accept_count), 32'(acc_before));
        exp_q.push_back(32'h0000_0080);
        exp_q.push_back(32'h0000_0084);
        waitRetireAll(20, "ready_redirect_timeout");
        if (acc_log.size() > acc_before) checkOutput("first_accepted_addr", acc_log[acc_before], 32'h0000_0080);
        else reportFail("first_accepted_addr_missing", acc_log.size(), acc_before + 1);

        $display("[TB] reset mid-stream");
        mem_lat = 3;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h0000_0088 + 32'(4 * i));
        waitAccept(20, "reset_accept_timeout");
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkResetOutputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        checkOutput("reboot_req_valid", {31'b0, imem_req_valid}, 32'd0);
        exp_q.push_back(32'h4000_0000);
        exp_q.push_back(32'h4000_0004);
        exp_q.push_back(32'h4000_0008);
        waitRetireAll(40, "restart_timeout");
        repeat (4) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
